// File: rtl/multi_duck_game_logic.sv
// Game controller for N ducks: ammo and reload, per-duck hit test, score, kill/death and game-over sequencing.
// Latency: button edges act two clocks after the button input rises; every output is a register.
// Backpressure: none. While in RELOAD, DEATH or GAME_OVER the fire and reload buttons are ignored.
module multi_duck_game_logic #(
    parameter int N_DUCKS    = 2,
    parameter int MAG_SIZE   = 3,
    parameter int RESERVE    = 15,
    parameter int DUCK_W     = 96,
    parameter int DUCK_H     = 60,
    parameter int COUNTDOWN  = 7500*65000,
    parameter int DEATH_CYC  = 4500*65000,
    parameter int DOG_CYC    = 2000*65000,
    parameter int RELOAD_CYC = 500*65000,
    parameter int SCORE_W    = 7
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [11:0]                     mouse_xpos,
    input  logic [11:0]                     mouse_ypos,
    input  logic                            left_mouse,
    input  logic                            right_mouse,
    input  logic                            game_enable,
    input  logic [12*N_DUCKS-1:0]           duck_xpos,
    input  logic [12*N_DUCKS-1:0]           duck_ypos,
    input  logic [N_DUCKS-1:0]              duck_active,
    output logic [$clog2(MAG_SIZE+1)-1:0]   bullets_in_magazine,
    output logic [$clog2(RESERVE+1)-1:0]    bullets_left,
    output logic [SCORE_W-1:0]              my_score,
    output logic                            hunt_start,
    output logic                            show_reload_char,
    output logic                            reloading,
    output logic [N_DUCKS-1:0]              duck_killed,
    output logic                            dog_bird_enable,
    output logic                            game_over
);

    localparam int MW = $clog2(MAG_SIZE+1);
    localparam int RW = $clog2(RESERVE+1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_COUNT  = 3'd1;
    localparam logic [2:0] S_HUNT   = 3'd2;
    localparam logic [2:0] S_RELOAD = 3'd3;
    localparam logic [2:0] S_DEATH  = 3'd4;
    localparam logic [2:0] S_OVER   = 3'd5;

    localparam logic [31:0] T_COUNT  = 32'(COUNTDOWN);
    localparam logic [31:0] T_DEATH  = 32'(DEATH_CYC);
    localparam logic [31:0] T_RELOAD = 32'(RELOAD_CYC);
    // Timer value at which DOG_CYC cycles of the death sequence have elapsed.
    localparam logic [31:0] T_DOG    = 32'(DEATH_CYC - DOG_CYC);

    logic [2:0]         state, state_n;
    logic [31:0]        timer, timer_n;
    logic [MW-1:0]      mag_n;
    logic [RW-1:0]      res_n;
    logic [SCORE_W-1:0] score_n;
    logic [N_DUCKS-1:0] killed_n;
    logic               dog_n;
    logic               left_q, left_prev, right_q, right_prev;
    logic               fire, rld;
    logic [N_DUCKS-1:0] hit_raw, hit_sel;
    logic [31:0]        space, xfer;
    logic [12:0]        mx, my;

    assign fire = left_q & ~left_prev;
    assign rld  = right_q & ~right_prev;
    assign mx   = {1'b0, mouse_xpos};
    assign my   = {1'b0, mouse_ypos};

    // Hit boxes are compared in 13 bits so a duck near x=4095 does not wrap around to 0.
    for (genvar g = 0; g < N_DUCKS; g++) begin : g_hit
        logic [12:0] dx, dy;
        assign dx = {1'b0, duck_xpos[12*g +: 12]};
        assign dy = {1'b0, duck_ypos[12*g +: 12]};
        assign hit_raw[g] = duck_active[g] && (mx >= dx) && (mx <= dx + 13'(DUCK_W))
                            && (my >= dy) && (my <= dy + 13'(DUCK_H));
    end

    // Only the lowest-indexed duck under the cursor is killed.
    assign hit_sel = hit_raw & (-hit_raw);

    // Rounds moved from reserve to magazine when a reload completes.
    assign space = 32'(MAG_SIZE) - 32'(bullets_in_magazine);
    assign xfer  = (space < 32'(bullets_left)) ? space : 32'(bullets_left);

    // Next-state and next-output computation; timers leave their state on reaching zero.
    always_comb begin
        state_n  = state;
        timer_n  = timer;
        mag_n    = bullets_in_magazine;
        res_n    = bullets_left;
        score_n  = my_score;
        killed_n = duck_killed;
        dog_n    = 1'b0;
        if (!game_enable) begin
            state_n  = S_IDLE;
            timer_n  = T_COUNT;
            mag_n    = MW'(MAG_SIZE);
            res_n    = RW'(RESERVE);
            score_n  = '0;
            killed_n = '0;
        end else begin
            case (state)
                S_IDLE: state_n = S_COUNT;
                S_COUNT: begin
                    if (timer <= 32'd1) begin
                        timer_n = '0;
                        state_n = S_HUNT;
                    end else begin
                        timer_n = timer - 32'd1;
                    end
                end
                S_HUNT: begin
                    if (bullets_in_magazine == '0 && bullets_left == '0) begin
                        state_n = S_OVER;
                    end else if (rld) begin
                        // A reload edge always discards a simultaneous shot.
                        if (bullets_in_magazine != MW'(MAG_SIZE) && bullets_left != '0) begin
                            state_n = S_RELOAD;
                            timer_n = T_RELOAD;
                        end
                    end else if (fire && bullets_in_magazine != '0) begin
                        mag_n = bullets_in_magazine - MW'(1);
                        if (|hit_sel) begin
                            killed_n = hit_sel;
                            score_n  = (&my_score) ? my_score : my_score + SCORE_W'(1);
                            state_n  = S_DEATH;
                            timer_n  = T_DEATH;
                        end
                    end
                end
                S_RELOAD: begin
                    if (timer <= 32'd1) begin
                        timer_n = '0;
                        mag_n   = MW'(32'(bullets_in_magazine) + xfer);
                        res_n   = RW'(32'(bullets_left) - xfer);
                        state_n = S_HUNT;
                    end else begin
                        timer_n = timer - 32'd1;
                    end
                end
                S_DEATH: begin
                    dog_n = (timer == T_DOG);
                    if (timer <= 32'd1) begin
                        timer_n  = '0;
                        killed_n = '0;
                        state_n  = S_HUNT;
                    end else begin
                        timer_n = timer - 32'd1;
                    end
                end
                S_OVER:  state_n = S_OVER;
                default: state_n = S_IDLE;
            endcase
        end
    end

    // State, timer, button history and all registered outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state               <= S_IDLE;
            timer               <= T_COUNT;
            bullets_in_magazine <= MW'(MAG_SIZE);
            bullets_left        <= RW'(RESERVE);
            my_score            <= '0;
            duck_killed         <= '0;
            dog_bird_enable     <= 1'b0;
            hunt_start          <= 1'b0;
            reloading           <= 1'b0;
            game_over           <= 1'b0;
            show_reload_char    <= 1'b0;
            left_q              <= 1'b0;
            left_prev           <= 1'b0;
            right_q             <= 1'b0;
            right_prev          <= 1'b0;
        end else begin
            state               <= state_n;
            timer               <= timer_n;
            bullets_in_magazine <= mag_n;
            bullets_left        <= res_n;
            my_score            <= score_n;
            duck_killed         <= killed_n;
            dog_bird_enable     <= dog_n;
            hunt_start          <= (state_n == S_HUNT) || (state_n == S_RELOAD);
            reloading           <= (state_n == S_RELOAD);
            game_over           <= (state_n == S_OVER);
            show_reload_char    <= (mag_n == '0) && (res_n != '0);
            left_q              <= left_mouse;
            left_prev           <= left_q;
            right_q             <= right_mouse;
            right_prev          <= right_q;
        end
    end

endmodule

// File: tb/tb_multi_duck_game_logic.sv
// Bench for multi_duck_game_logic: hit-test vector table plus hand-written reload, game-over and abort sequences.
// Expected results are pushed to a queue when a shot or reload is driven and popped when the DUT finishes it.
// Outputs are sampled 1 time unit after the rising clock edge.
module tb_multi_duck_game_logic;

    localparam int CD = 40, DC = 20, DG = 5, RC = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [11:0] mouse_xpos = '0, mouse_ypos = '0;
    logic        left_mouse = 1'b0, right_mouse = 1'b0, game_enable = 1'b0;
    logic [23:0] duck_xpos = '0, duck_ypos = '0;
    logic [1:0]  duck_active = '0;
    logic [1:0]  bullets_in_magazine;
    logic [3:0]  bullets_left;
    logic [6:0]  my_score;
    logic        hunt_start, show_reload_char, reloading, dog_bird_enable, game_over;
    logic [1:0]  duck_killed;

    multi_duck_game_logic #(
        .N_DUCKS(2), .MAG_SIZE(3), .RESERVE(15), .DUCK_W(96), .DUCK_H(60),
        .COUNTDOWN(CD), .DEATH_CYC(DC), .DOG_CYC(DG), .RELOAD_CYC(RC), .SCORE_W(7)
    ) dut (
        .clk(clk), .rst(rst),
        .mouse_xpos(mouse_xpos), .mouse_ypos(mouse_ypos),
        .left_mouse(left_mouse), .right_mouse(right_mouse), .game_enable(game_enable),
        .duck_xpos(duck_xpos), .duck_ypos(duck_ypos), .duck_active(duck_active),
        .bullets_in_magazine(bullets_in_magazine), .bullets_left(bullets_left),
        .my_score(my_score), .hunt_start(hunt_start), .show_reload_char(show_reload_char),
        .reloading(reloading), .duck_killed(duck_killed), .dog_bird_enable(dog_bird_enable),
        .game_over(game_over)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] x0, y0, x1, y1;
        logic [1:0]  act;
        logic [11:0] mx, my;
        logic [1:0]  exp_kill;
    } shot_t;

    typedef struct {
        logic [1:0] kill;
        int         score;
        int         mag;
        int         res;
    } exp_t;

    exp_t  sbq[$];
    shot_t tbl[11];
    shot_t miss_v;
    int    tests = 0, failed = 0;
    int    m = 3, r = 15, sc = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            failed++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic pop_exp(output exp_t e);
        tests++;
        if (sbq.size() == 0) begin
            failed++;
            $display("FAIL scoreboard: got empty queue, required 1 entry");
            e = '{2'b00, -1, -1, -1};
        end else begin
            e = sbq.pop_front();
        end
    endtask

    // Waits (bounded) for hunt_start after enabling; the countdown is CD cycles after the IDLE exit.
    task automatic wait_hunt(input string name);
        int n = 0;
        game_enable = 1'b1;
        for (int c = 0; c < 200; c++) begin
            tick();
            n++;
            if (hunt_start) break;
        end
        check(name, n, CD + 1);
    endtask

    task automatic do_shot(input shot_t v, input string name);
        exp_t e;
        int dl = 0, dogs = 0;
        logic [1:0] kseen = 2'b00;
        duck_xpos = {v.x1, v.x0};
        duck_ypos = {v.y1, v.y0};
        duck_active = v.act;
        mouse_xpos = v.mx;
        mouse_ypos = v.my;
        m--;
        if (v.exp_kill != 2'b00 && sc < 127) sc++;
        sbq.push_back('{v.exp_kill, sc, m, r});
        left_mouse = 1'b1;
        tick();
        tick();
        left_mouse = 1'b0;
        for (int c = 0; c < 60; c++) begin
            if (dog_bird_enable) dogs++;
            if (duck_killed != 2'b00) begin
                if (kseen == 2'b00) kseen = duck_killed;
                dl++;
            end else if (c >= 4) begin
                break;
            end
            tick();
        end
        pop_exp(e);
        check({name, " killed"}, kseen, e.kill);
        check({name, " score"}, my_score, e.score);
        check({name, " mag"}, bullets_in_magazine, e.mag);
        check({name, " reserve"}, bullets_left, e.res);
        check({name, " reload_char"}, show_reload_char, (e.mag == 0 && e.res > 0) ? 1 : 0);
        check({name, " hunt_start"}, hunt_start, (e.mag == 0 && e.res == 0) ? 0 : 1);
        if (e.kill != 2'b00) begin
            check({name, " death_len"}, dl, DC);
            check({name, " dog_pulses"}, dogs, 1);
        end
    endtask

    // Reload, with a fire attempt mid-reload; with_fire also fires on the same cycle as the reload press.
    task automatic do_reload(input bit with_fire, input string name);
        exp_t e;
        int cnt = 0, k;
        int old_m = m;
        bit mag_moved = 1'b0;
        k = (3 - m < r) ? 3 - m : r;
        m += k;
        r -= k;
        sbq.push_back('{2'b00, sc, m, r});
        right_mouse = 1'b1;
        if (with_fire) left_mouse = 1'b1;
        tick();
        tick();
        right_mouse = 1'b0;
        left_mouse = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (reloading) begin
                cnt++;
                if (bullets_in_magazine != 2'(old_m)) mag_moved = 1'b1;
                if (cnt == 3) left_mouse = 1'b1;
                if (cnt == 5) left_mouse = 1'b0;
            end else if (cnt > 0 || c > 5) begin
                break;
            end
            tick();
        end
        left_mouse = 1'b0;
        pop_exp(e);
        check({name, " reload_len"}, cnt, RC);
        check({name, " mag_held"}, mag_moved, 0);
        check({name, " mag"}, bullets_in_magazine, e.mag);
        check({name, " reserve"}, bullets_left, e.res);
        check({name, " hunt_start"}, hunt_start, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{12'd100, 12'd100, 12'd600, 12'd600, 2'b01, 12'd196, 12'd160, 2'b01};
        tbl[1]  = '{12'd100, 12'd100, 12'd600, 12'd600, 2'b01, 12'd197, 12'd160, 2'b00};
        tbl[2]  = '{12'd100, 12'd100, 12'd600, 12'd600, 2'b01, 12'd100, 12'd100, 2'b01};
        tbl[3]  = '{12'd100, 12'd100, 12'd600, 12'd600, 2'b01, 12'd99,  12'd130, 2'b00};
        tbl[4]  = '{12'd100, 12'd100, 12'd600, 12'd600, 2'b01, 12'd150, 12'd161, 2'b00};
        tbl[5]  = '{12'd100, 12'd100, 12'd120, 12'd110, 2'b11, 12'd150, 12'd130, 2'b01};
        tbl[6]  = '{12'd100, 12'd100, 12'd120, 12'd110, 2'b10, 12'd150, 12'd130, 2'b10};
        tbl[7]  = '{12'd4050, 12'd100, 12'd600, 12'd600, 2'b01, 12'd4095, 12'd120, 2'b01};
        tbl[8]  = '{12'd4050, 12'd4050, 12'd600, 12'd600, 2'b01, 12'd10, 12'd10, 2'b00};
        tbl[9]  = '{12'd300, 12'd200, 12'd300, 12'd400, 2'b11, 12'd396, 12'd460, 2'b10};
        tbl[10] = '{12'd100, 12'd100, 12'd120, 12'd110, 2'b00, 12'd150, 12'd130, 2'b00};
        miss_v  = '{12'd100, 12'd100, 12'd120, 12'd110, 2'b00, 12'd150, 12'd130, 2'b00};

        // Reset state.
        rst = 1'b0;
        tick();
        tick();
        tick();
        check("rst mag", bullets_in_magazine, 3);
        check("rst reserve", bullets_left, 15);
        check("rst score", my_score, 0);
        check("rst hunt", hunt_start, 0);
        check("rst killed", duck_killed, 0);
        check("rst over", game_over, 0);
        check("rst reloading", reloading, 0);
        rst = 1'b1;
        tick();

        wait_hunt("countdown");

        // Hit-test vectors; reload whenever the magazine runs dry.
        for (int i = 0; i < 11; i++) begin
            if (m == 0) do_reload(1'b0, $sformatf("tbl%0d pre-reload", i));
            do_shot(tbl[i], $sformatf("tbl%0d", i));
        end

        // Walk ammo down to magazine 1, reserve 1.
        for (int it = 0; it < 40 && !(m == 1 && r == 1); it++) begin
            if (r > 1 && m < 3) do_reload(1'b0, "walk reload");
            else do_shot(miss_v, "walk miss");
        end
        check("walk mag", bullets_in_magazine, 1);
        check("walk reserve", bullets_left, 1);

        // Fire and reload together: reload wins, reserve limits the transfer.
        do_reload(1'b1, "fire+reload");

        // Empty everything: game over, frozen.
        do_shot(miss_v, "drain1");
        do_shot(miss_v, "drain2");
        check("over flag", game_over, 1);
        left_mouse = 1'b1;
        tick();
        tick();
        left_mouse = 1'b0;
        tick();
        tick();
        check("over frozen mag", bullets_in_magazine, 0);
        check("over still", game_over, 1);

        // Enable drop from GAME_OVER.
        game_enable = 1'b0;
        tick();
        tick();
        check("idle over", game_over, 0);
        check("idle mag", bullets_in_magazine, 3);
        check("idle reserve", bullets_left, 15);
        m = 3; r = 15; sc = 0;

        // Enable drop in the middle of DEATH.
        wait_hunt("countdown2");
        duck_xpos = {12'd600, 12'd100};
        duck_ypos = {12'd600, 12'd100};
        duck_active = 2'b01;
        mouse_xpos = 12'd150;
        mouse_ypos = 12'd130;
        left_mouse = 1'b1;
        tick();
        tick();
        left_mouse = 1'b0;
        check("abort killed", duck_killed, 1);
        check("abort score", my_score, 1);
        for (int c = 0; c < 5; c++) tick();
        game_enable = 1'b0;
        tick();
        tick();
        check("abort killed clr", duck_killed, 0);
        check("abort mag", bullets_in_magazine, 3);
        check("abort reserve", bullets_left, 15);
        check("abort score clr", my_score, 0);
        check("abort hunt", hunt_start, 0);

        // Reset in the middle of RELOAD.
        wait_hunt("countdown3");
        do_shot(miss_v, "pre-rst miss");
        right_mouse = 1'b1;
        tick();
        tick();
        right_mouse = 1'b0;
        check("rst-reload entered", reloading, 1);
        tick();
        tick();
        rst = 1'b0;
        tick();
        tick();
        check("rst-reload reloading", reloading, 0);
        check("rst-reload mag", bullets_in_magazine, 3);
        check("rst-reload reserve", bullets_left, 15);
        check("rst-reload hunt", hunt_start, 0);
        rst = 1'b1;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
